// File: rtl/tx_frame_arbiter.sv
// Frame-atomic arbiter for the shared UART transmit byte channel.
// Requester 0 has strict priority, the others rotate; a watchdog drops stalled producers.
module tx_frame_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_REQ-1:0]   req_bus,
  input  logic [8*N_REQ-1:0] in_data_bus,
  input  logic [N_REQ-1:0]   in_valid_bus,
  input  logic [N_REQ-1:0]   in_last_bus,
  output logic [N_REQ-1:0]   in_ready_bus,
  output logic [N_REQ-1:0]   grant_bus,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               abort_pulse,
  output logic [7:0]         abort_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    rr_reg, rr_next;
  logic [7:0]       timer_reg, timer_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             abort_pulse_reg, abort_pulse_next;
  logic [7:0]       abort_cnt_reg, abort_cnt_next;

  logic [7:0]    lane_data [N_REQ];
  logic [7:0]    sel_data;
  logic [IW-1:0] g_idx;
  logic          sel_last;
  logic          accept;
  logic          starve;
  logic          rr_found;
  logic [IW-1:0] rr_win;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = grant_reg[gi] ? in_data_bus[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    g_idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data = sel_data | lane_data[i];
      if (grant_reg[i]) g_idx = IW'(i);
    end
  end

  // tx_valid blocks the next accept so the transmitter sees one strobe per byte.
  assign in_ready_bus = (state_reg == XFER && tx_ready && !tx_valid_reg) ? grant_reg : '0;
  assign sel_last     = |(grant_reg & in_last_bus);
  assign accept       = |(in_ready_bus & in_valid_bus);
  assign starve       = |(in_ready_bus & ~in_valid_bus);

  // Rotating search over 1..N_REQ-1 starting just after the last served index.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    return IW'(((int'(base) - 1 + k) % (N_REQ - 1)) + 1);
  endfunction

  always_comb begin
    rr_found = 1'b0;
    rr_win   = rr_reg;
    for (int k = 1; k < N_REQ; k++) begin
      if (!rr_found && req_bus[rr_index(rr_reg, k)]) begin
        rr_found = 1'b1;
        rr_win   = rr_index(rr_reg, k);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    rr_next          = rr_reg;
    timer_next       = timer_reg;
    tx_data_next     = tx_data_reg;
    tx_valid_next    = 1'b0;
    abort_pulse_next = 1'b0;
    abort_cnt_next   = abort_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_bus[0]) begin
          grant_next = N_REQ'(1);
          timer_next = '0;
          state_next = XFER;
        end else if (rr_found) begin
          grant_next = N_REQ'(1) << rr_win;
          timer_next = '0;
          state_next = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          tx_data_next  = sel_data;
          tx_valid_next = 1'b1;
          timer_next    = '0;
          if (sel_last) begin
            state_next = IDLE;
            grant_next = '0;
            if (g_idx != '0) rr_next = g_idx;
          end
        end else if (starve) begin
          if (timer_reg == TIMER_LAST) begin
            abort_pulse_next = 1'b1;
            if (abort_cnt_reg != 8'hFF) abort_cnt_next = abort_cnt_reg + 8'd1;
            state_next = IDLE;
            grant_next = '0;
            timer_next = '0;
            if (g_idx != '0) rr_next = g_idx;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      rr_reg          <= IW'(N_REQ - 1);
      timer_reg       <= '0;
      tx_data_reg     <= '0;
      tx_valid_reg    <= 1'b0;
      abort_pulse_reg <= 1'b0;
      abort_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      rr_reg          <= rr_next;
      timer_reg       <= timer_next;
      tx_data_reg     <= tx_data_next;
      tx_valid_reg    <= tx_valid_next;
      abort_pulse_reg <= abort_pulse_next;
      abort_cnt_reg   <= abort_cnt_next;
    end
  end

  assign grant_bus   = grant_reg;
  assign tx_data     = tx_data_reg;
  assign tx_valid    = tx_valid_reg;
  assign abort_pulse = abort_pulse_reg;
  assign abort_cnt   = abort_cnt_reg;
  assign busy        = (state_reg == XFER);

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: arbitration vector table plus frame-level sequences.
module tb_tx_frame_arbiter;

  logic        clk;
  logic        n_rst;
  logic [3:0]  req_bus;
  logic [31:0] in_data_bus;
  logic [3:0]  in_valid_bus;
  logic [3:0]  in_last_bus;
  logic [3:0]  in_ready_bus;
  logic [3:0]  grant_bus;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        abort_pulse;
  logic [7:0]  abort_cnt;

  tx_frame_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .n_rst(n_rst), .req_bus(req_bus), .in_data_bus(in_data_bus),
    .in_valid_bus(in_valid_bus), .in_last_bus(in_last_bus), .in_ready_bus(in_ready_bus),
    .grant_bus(grant_bus), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .abort_pulse(abort_pulse), .abort_cnt(abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] exp_grant;
  } arb_vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;

  // Producer model: per-requester byte lists with a read pointer.
  logic [7:0] fdata [4][16];
  logic       flast [4][16];
  int         flen [4];
  int         fpos [4];
  logic [3:0] hold_valid;

  // Transmitter model: ready drops for tx_gap cycles after every strobe.
  int   tx_gap;
  int   tx_hold;
  logic stall;

  logic [3:0] prev_grant;
  int out_log[$];
  int out_t[$];
  int out_busy[$];
  int glog[$];
  int glog_t[$];
  int abort_t[$];
  int abort_grant[$];

  function automatic int outv(input int k);
    return (k < out_log.size()) ? out_log[k] : -1;
  endfunction
  function automatic int outt(input int k);
    return (k < out_t.size()) ? out_t[k] : -1;
  endfunction
  function automatic int gv(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction
  function automatic int gt(input int k);
    return (k < glog_t.size()) ? glog_t[k] : -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  task automatic expire(input string name, input int budget);
    total++;
    bad++;
    $display("FAIL %s: no progress within %0d cycles", name, budget);
  endtask

  task automatic clear_logs();
    out_log.delete(); out_t.delete(); out_busy.delete();
    glog.delete(); glog_t.delete(); abort_t.delete(); abort_grant.delete();
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 4; i++) begin
      flen[i] = 0;
      fpos[i] = 0;
    end
    hold_valid = '0;
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    fdata[r][flen[r]] = d;
    flast[r][flen[r]] = last;
    flen[r]++;
  endtask

  task automatic drive_producers();
    for (int i = 0; i < 4; i++) begin
      if (fpos[i] < flen[i]) begin
        req_bus[i]          = 1'b1;
        in_valid_bus[i]     = !hold_valid[i];
        in_data_bus[8*i+:8] = fdata[i][fpos[i]];
        in_last_bus[i]      = flast[i][fpos[i]];
      end else begin
        req_bus[i]          = 1'b0;
        in_valid_bus[i]     = 1'b0;
        in_data_bus[8*i+:8] = 8'h00;
        in_last_bus[i]      = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_valid) begin
      out_log.push_back(int'(tx_data));
      out_t.push_back(cyc);
      out_busy.push_back(int'(busy));
      $display("tx byte=%02h busy=%0b cycle=%0d", tx_data, busy, cyc);
      tx_hold = tx_gap;
    end else if (tx_hold > 0) begin
      tx_hold--;
    end
    if (grant_bus != 4'b0000 && prev_grant == 4'b0000) begin
      glog.push_back(int'(grant_bus));
      glog_t.push_back(cyc);
    end
    prev_grant = grant_bus;
    if (abort_pulse) begin
      abort_t.push_back(cyc);
      abort_grant.push_back(int'(grant_bus));
    end
    tx_ready = (tx_hold == 0) && !stall;
    drive_producers();
    #1;
    for (int i = 0; i < 4; i++) begin
      if (in_valid_bus[i] && in_ready_bus[i]) begin
        fpos[i]++;
        pops++;
      end
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    clear_frames();
    stall      = 1'b0;
    tx_hold    = 0;
    tx_gap     = 4;
    tx_ready   = 1'b1;
    prev_grant = '0;
    drive_producers();
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          {grant_bus, in_ready_bus, tx_valid, tx_data, abort_pulse, abort_cnt, busy}, 32'h0);
    n_rst = 1'b1;
    clear_logs();
  endtask

  task automatic run_out(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (out_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (out_log.size() < n) expire(name, budget);
  endtask

  task automatic run_pos(input int r, input int p, input int budget, input string name);
    int c;
    c = 0;
    while (fpos[r] < p && c < budget) begin
      tick();
      c++;
    end
    if (fpos[r] < p) expire(name, budget);
  endtask

  arb_vec_t vecs[12];

  initial begin
    int c;
    int gbad;
    int idx;
    string nm;

    n_rst = 1'b0;
    req_bus = '0; in_data_bus = '0; in_valid_bus = '0; in_last_bus = '0;
    tx_ready = 1'b1;

    // Expected winners trace the rotating pointer from its reset value of 3.
    vecs[0]  = '{4'b1110, 4'b0010};
    vecs[1]  = '{4'b1110, 4'b0100};
    vecs[2]  = '{4'b1111, 4'b0001};
    vecs[3]  = '{4'b1010, 4'b1000};
    vecs[4]  = '{4'b0110, 4'b0010};
    vecs[5]  = '{4'b0010, 4'b0010};
    vecs[6]  = '{4'b1100, 4'b0100};
    vecs[7]  = '{4'b0011, 4'b0001};
    vecs[8]  = '{4'b1010, 4'b1000};
    vecs[9]  = '{4'b1100, 4'b0100};
    vecs[10] = '{4'b1010, 4'b1000};
    vecs[11] = '{4'b0001, 4'b0001};

    // Arbitration table: one-byte frames, only the winning frame completes per vector.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      clear_logs();
      pops = 0;
      for (int i = 0; i < 4; i++)
        if (vecs[v].mask[i]) add_byte(i, 8'(v * 16 + i), 1'b1);
      c = 0;
      while (pops < 1 && c < 40) begin
        tick();
        c++;
      end
      if (pops < 1) expire($sformatf("vec%0d_accept", v), 40);
      clear_frames();
      repeat (6) tick();
      idx = 0;
      for (int j = 0; j < 4; j++) if (vecs[v].exp_grant[j]) idx = j;
      check($sformatf("vec%0d_grant", v), gv(0), int'(vecs[v].exp_grant));
      check($sformatf("vec%0d_data", v), outv(0), v * 16 + idx);
    end

    // Single three-byte frame from requester 1.
    do_reset();
    add_byte(1, 8'hA5, 1'b0); add_byte(1, 8'h01, 1'b0); add_byte(1, 8'h02, 1'b1);
    gbad = 0;
    c = 0;
    while (out_log.size() < 3 && c < 100) begin
      tick();
      if (busy && grant_bus !== 4'b0010) gbad++;
      c++;
    end
    if (out_log.size() < 3) expire("single_frame", 100);
    check("single_b0", outv(0), 32'hA5);
    check("single_b1", outv(1), 32'h01);
    check("single_b2", outv(2), 32'h02);
    check("single_grant", gv(0), 32'h2);
    check("single_grant_held", gbad, 0);
    check("single_busy_mid", out_busy.size() > 1 ? out_busy[1] : -1, 1);
    check("single_busy_fall", out_busy.size() > 2 ? out_busy[2] : -1, 0);
    check("single_abort_cnt", abort_cnt, 0);

    // Requester 0 and 2 together: 0 completes first, no interleave.
    do_reset();
    add_byte(0, 8'hC0, 1'b0); add_byte(0, 8'hC1, 1'b1);
    add_byte(2, 8'hE0, 1'b0); add_byte(2, 8'hE1, 1'b1);
    run_out(4, 100, "priority");
    check("prio_b0", outv(0), 32'hC0);
    check("prio_b1", outv(1), 32'hC1);
    check("prio_b2", outv(2), 32'hE0);
    check("prio_b3", outv(3), 32'hE1);
    check("prio_g0", gv(0), 32'h1);
    check("prio_g1", gv(1), 32'h4);

    // Round-robin among 1..3 with continuous one-byte frames.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      add_byte(1, 8'h11, 1'b1); add_byte(2, 8'h22, 1'b1); add_byte(3, 8'h33, 1'b1);
    end
    run_out(6, 200, "round_robin");
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_data%0d", k), outv(k), (k % 3 + 1) * 32'h11);
      check($sformatf("rr_grant%0d", k), gv(k), 32'h1 << (k % 3 + 1));
    end

    // Watchdog: requester 1 goes silent with the transmitter free, requester 2 waits.
    do_reset();
    tx_gap = 0;
    add_byte(1, 8'hB1, 1'b0); add_byte(1, 8'hB2, 1'b1);
    add_byte(2, 8'hD1, 1'b1);
    run_pos(1, 1, 50, "wd_first_byte");
    hold_valid[1] = 1'b1;
    run_out(2, 80, "wd_next_frame");
    check("wd_b0", outv(0), 32'hB1);
    check("wd_b1_from_req2", outv(1), 32'hD1);
    check("wd_abort_pulses", abort_t.size(), 1);
    check("wd_abort_delay", abort_t.size() > 0 ? abort_t[0] - outt(0) : -1, 9);
    check("wd_abort_grant_clear", abort_grant.size() > 0 ? abort_grant[0] : -1, 0);
    check("wd_abort_cnt", abort_cnt, 1);
    check("wd_regrant", gv(1), 32'h4);
    check("wd_regrant_delay", gt(1) - outt(0), 10);

    // Long transmitter stall with the producer also idle must not abort.
    do_reset();
    add_byte(1, 8'h71, 1'b0); add_byte(1, 8'h72, 1'b1);
    run_pos(1, 1, 50, "stall_first_byte");
    stall = 1'b1;
    hold_valid[1] = 1'b1;
    repeat (300) tick();
    check("stall_held_bytes", out_log.size(), 1);
    check("stall_busy", busy, 1);
    check("stall_abort_cnt", abort_cnt, 0);
    stall = 1'b0;
    hold_valid[1] = 1'b0;
    run_out(2, 50, "stall_resume");
    repeat (3) tick();
    check("stall_b1", outv(1), 32'h72);
    check("stall_no_pulse", abort_t.size(), 0);
    check("stall_busy_end", busy, 0);

    // Reset mid-frame after moving the pointer to 2.
    do_reset();
    add_byte(2, 8'h5A, 1'b1);
    run_pos(2, 1, 50, "rst_pre_frame");
    clear_frames();
    repeat (6) tick();
    for (int k = 0; k < 5; k++) add_byte(1, 8'(8'h61 + k), k == 4);
    run_out(3, 100, "rst_two_bytes");
    check("rst_mid_b2", outv(2), 32'h62);
    n_rst = 1'b0;
    #1;
    check("rst_async_tx", {tx_valid, tx_data}, 32'h0);
    check("rst_async_grant", {busy, grant_bus, in_ready_bus}, 32'h0);
    check("rst_async_abort", {abort_pulse, abort_cnt}, 32'h0);
    clear_frames();
    clear_logs();
    tx_hold = 0;
    add_byte(1, 8'h81, 1'b1); add_byte(2, 8'h82, 1'b1); add_byte(3, 8'h83, 1'b1);
    repeat (2) tick();
    check("rst_no_grant_in_reset", glog.size(), 0);
    n_rst = 1'b1;
    run_out(1, 50, "rst_after_release");
    check("rst_first_grant", gv(0), 32'h2);
    check("rst_first_data", outv(0), 32'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
